// File: rtl/upg_loader.sv
// Byte-stream upgrade loader: parses sync/target/count frames from a UART byte
// stream and emits one 32-bit memory write strobe per assembled word.
module upg_loader (
  input  logic        upg_clk_i,
  input  logic        upg_rst_n_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE,
    TARGET,
    CNT_LO,
    CNT_HI,
    DATA,
    DONE
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h55;

  state_e      state_q,    state_d;
  logic        target_q,   target_d;
  logic [7:0]  cnt_lo_q,   cnt_lo_d;
  logic [13:0] count_q,    count_d;
  logic [13:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  // Only bytes 0..2 are buffered; byte 3 goes straight into the write word.
  logic [23:0] word_q,     word_d;
  logic        wen_q,      wen_d;
  logic [14:0] adr_q,      adr_d;
  logic [31:0] dat_q,      dat_d;
  logic        err_q,      err_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave it unassigned (no latch).
    state_d    = state_q;
    target_d   = target_q;
    cnt_lo_d   = cnt_lo_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    wen_d      = 1'b0;
    adr_d      = adr_q;
    dat_d      = dat_q;
    err_d      = err_q;

    if (rx_valid_i) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data_i == SYNC_BYTE) state_d = TARGET;
        end
        TARGET: begin
          if (rx_data_i == 8'h00 || rx_data_i == 8'h01) begin
            target_d = rx_data_i[0];
            state_d  = CNT_LO;
          end else if (rx_data_i == 8'hFF) begin
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        CNT_LO: begin
          cnt_lo_d = rx_data_i;
          state_d  = CNT_HI;
        end
        CNT_HI: begin
          if (rx_data_i[7:6] != 2'b00) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if ({rx_data_i, cnt_lo_q} == 16'h0000) begin
            state_d = IDLE;
          end else begin
            count_d    = {rx_data_i[5:0], cnt_lo_q};
            word_idx_d = '0;
            byte_idx_d = '0;
            state_d    = DATA;
          end
        end
        DATA: begin
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_d[7:0]   = rx_data_i;
            2'd1: word_d[15:8]  = rx_data_i;
            2'd2: word_d[23:16] = rx_data_i;
            2'd3: begin
              wen_d      = 1'b1;
              dat_d      = {rx_data_i, word_q};
              adr_d      = {target_q, word_idx_q};
              word_idx_d = word_idx_q + 14'd1;
              // Leave DATA on the last byte so a following sync byte is taken next cycle.
              if (word_idx_q == count_q - 14'd1) state_d = IDLE;
            end
            default: ;
          endcase
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) begin
      state_q    <= IDLE;
      target_q   <= 1'b0;
      cnt_lo_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      wen_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      cnt_lo_q   <= cnt_lo_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      wen_q      <= wen_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      err_q      <= err_d;
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = (state_q == DONE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_upg_loader.sv
// Directed bench for upg_loader: byte frames in, captured write strobes checked
// against hand-computed addresses, data and strobe spacing.
module tb_upg_loader;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wen;
  logic [14:0] adr;
  logic [31:0] dat;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [46:0] wr_q[$];
  int          wc_q[$];
  logic [7:0]  tx[$];

  upg_loader dut (
    .upg_clk_i   (clk),
    .upg_rst_n_i (rst_n),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .upg_wen_o   (wen),
    .upg_adr_o   (adr),
    .upg_dat_o   (dat),
    .upg_done_o  (done),
    .err_o       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe half a cycle after the edge that raised it.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      wr_q.push_back({adr, dat});
      wc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends queued bytes on consecutive cycles; returns at a negedge.
  task automatic send_tx();
    foreach (tx[i]) begin
      rx_valid = 1'b1;
      rx_data  = tx[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
    tx.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_wr(input string tag, input logic [14:0] a, input logic [31:0] d,
                           output int wcyc);
    logic [46:0] e;
    wcyc = -1;
    check({tag, " present"}, 32'(wr_q.size() != 0), 32'd1);
    if (wr_q.size() != 0) begin
      e    = wr_q.pop_front();
      wcyc = wc_q.pop_front();
      check({tag, " adr"}, 32'(e[46:32]), 32'(a));
      check({tag, " dat"}, e[31:0], d);
    end
  endtask

  task automatic expect_no_more(input string tag);
    check({tag, " extra strobes"}, 32'(wr_q.size()), 32'd0);
    wr_q.delete();
    wc_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " wen"},  32'(wen),  32'd0);
    check({tag, " adr"},  32'(adr),  32'd0);
    check({tag, " dat"},  dat,       32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"},  32'(err),  32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_zero_outputs("reset pulse");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_q.delete();
    wc_q.delete();
  endtask

  initial begin
    int c0, c1, c2;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(2);
    check_zero_outputs("por");
    rst_n = 1'b1;
    idle(1);

    // Non-sync bytes in IDLE are ignored without error.
    tx = '{8'h12, 8'h00, 8'hFF};
    send_tx();
    idle(2);
    check("idle junk err", 32'(err), 32'd0);
    expect_no_more("idle junk");

    // Two-word frame, then a new frame's sync in the very next cycle.
    tx = '{8'h55, 8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'hEF, 8'hBE, 8'hAD, 8'hDE,
           8'h55, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_tx();
    idle(3);
    expect_wr("f1 w0", 15'h0000, 32'h12345678, c0);
    expect_wr("f1 w1", 15'h0001, 32'hDEADBEEF, c1);
    expect_wr("f2 w0", 15'h0000, 32'h04030201, c2);
    expect_no_more("f1f2");
    check("f2 hold adr", 32'(adr), 32'h0000);
    check("f2 hold dat", dat, 32'h04030201);
    check("f2 err", 32'(err), 32'd0);

    // Bad target sets sticky error; a later good frame still writes.
    tx = '{8'h55, 8'h07};
    send_tx();
    idle(2);
    check("bad target err", 32'(err), 32'd1);
    expect_no_more("bad target");
    tx = '{8'h55, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_tx();
    idle(2);
    expect_wr("after err", 15'h0000, 32'hDDCCBBAA, c0);
    expect_no_more("after err");
    check("err sticky", 32'(err), 32'd1);

    // Count boundaries: zero count is silent, count[15:14]!=0 errors.
    pulse_reset();
    tx = '{8'h55, 8'h00, 8'h00, 8'h00};
    send_tx();
    idle(2);
    check("cnt0 err", 32'(err), 32'd0);
    expect_no_more("cnt0");
    tx = '{8'h55, 8'h00, 8'h00, 8'h40};
    send_tx();
    idle(2);
    check("cnt hi err", 32'(err), 32'd1);
    expect_no_more("cnt hi");
    tx = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h01, 8'h00,
           8'h01, 8'h00, 8'h00, 8'h00};
    send_tx();
    idle(2);
    expect_wr("post cnt err", 15'h0000, 32'h00000001, c0);
    expect_no_more("post cnt err");
    check("cnt err sticky", 32'(err), 32'd1);

    // Reset after two data bytes discards the partial word.
    tx = '{8'h55, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    send_tx();
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("mid-word reset");
    @(negedge clk);
    rst_n = 1'b1;
    tx = '{8'h33, 8'h44, 8'h55, 8'h00, 8'h01, 8'h00,
           8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_tx();
    idle(2);
    expect_wr("after reset", 15'h0000, 32'hD4C3B2A1, c0);
    expect_no_more("after reset");

    // Continuous stream: three words, strobes exactly four cycles apart.
    tx = '{8'h55, 8'h00, 8'h03, 8'h00};
    for (int i = 0; i < 12; i++) tx.push_back(8'(i));
    send_tx();
    idle(2);
    expect_wr("stream w0", 15'h0000, 32'h03020100, c0);
    expect_wr("stream w1", 15'h0001, 32'h07060504, c1);
    expect_wr("stream w2", 15'h0002, 32'h0B0A0908, c2);
    expect_no_more("stream");
    check("stream gap01", 32'(c1 - c0), 32'd4);
    check("stream gap12", 32'(c2 - c1), 32'd4);

    // Data-memory target, then programming-done lockout.
    tx = '{8'h55, 8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFF};
    send_tx();
    idle(2);
    expect_wr("dmem", 15'h4000, 32'h44332211, c0);
    expect_no_more("dmem");
    check("done set", 32'(done), 32'd1);
    tx = '{8'h55, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_tx();
    idle(2);
    expect_no_more("done lockout");
    check("done held", 32'(done), 32'd1);
    check("done hold adr", 32'(adr), 32'h4000);
    check("done err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
